// File: rtl/alu_issue_arbiter_pkg.sv
// Shared constants for the integer issue path: ALU op encodings, datapath and rrf tag widths.
package alu_issue_arbiter_pkg;

  localparam int ALU_OP_WIDTH = 4;
  localparam int XPR_LEN      = 32;
  localparam int TAG_W        = 6;
  localparam int CNT_W        = 16;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 4'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 4'd15;

  // Winner among the valid requesters; rr breaks a tie.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic rr);
    logic idx;
    if (v0 && v1) begin
      idx = rr;
    end else if (v1) begin
      idx = 1'b1;
    end else begin
      idx = 1'b0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_alu.sv
// Combinational integer ALU; undefined op encodings produce zero.
module alu_issue_arbiter_alu #(
  parameter int ALU_OP_WIDTH = alu_issue_arbiter_pkg::ALU_OP_WIDTH,
  parameter int XPR_LEN      = alu_issue_arbiter_pkg::XPR_LEN
) (
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [XPR_LEN-1:0]      in1,
  input  logic [XPR_LEN-1:0]      in2,
  output logic [XPR_LEN-1:0]      out
);
  import alu_issue_arbiter_pkg::*;

  localparam int SHW = $clog2(XPR_LEN);

  logic [SHW-1:0] shamt_s;
  logic           flag_s;

  assign shamt_s = in2[SHW-1:0];

  // Op decode and evaluation.
  always_comb begin
    out    = {XPR_LEN{1'b0}};
    flag_s = 1'b0;
    case (op)
      ALU_OP_ADD:  out = in1 + in2;
      ALU_OP_SUB:  out = in1 - in2;
      ALU_OP_SLL:  out = in1 << shamt_s;
      ALU_OP_SRL:  out = in1 >> shamt_s;
      ALU_OP_SRA:  out = $unsigned($signed(in1) >>> shamt_s);
      ALU_OP_XOR:  out = in1 ^ in2;
      ALU_OP_OR:   out = in1 | in2;
      ALU_OP_AND:  out = in1 & in2;
      ALU_OP_SEQ:  begin flag_s = (in1 == in2); out = {{(XPR_LEN-1){1'b0}}, flag_s}; end
      ALU_OP_SNE:  begin flag_s = (in1 != in2); out = {{(XPR_LEN-1){1'b0}}, flag_s}; end
      ALU_OP_SLT:  begin flag_s = ($signed(in1) <  $signed(in2)); out = {{(XPR_LEN-1){1'b0}}, flag_s}; end
      ALU_OP_SGE:  begin flag_s = ($signed(in1) >= $signed(in2)); out = {{(XPR_LEN-1){1'b0}}, flag_s}; end
      ALU_OP_SLTU: begin flag_s = (in1 <  in2); out = {{(XPR_LEN-1){1'b0}}, flag_s}; end
      ALU_OP_SGEU: begin flag_s = (in1 >= in2); out = {{(XPR_LEN-1){1'b0}}, flag_s}; end
      default:     out = {XPR_LEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue into one shared ALU, with a 1-deep tagged result
// register handed to writeback over valid/ready, flush via kill, and perf counters.
module alu_issue_arbiter #(
  parameter int ALU_OP_WIDTH = alu_issue_arbiter_pkg::ALU_OP_WIDTH,
  parameter int XPR_LEN      = alu_issue_arbiter_pkg::XPR_LEN,
  parameter int TAG_W        = alu_issue_arbiter_pkg::TAG_W,
  parameter int CNT_W        = alu_issue_arbiter_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    kill,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [ALU_OP_WIDTH-1:0] req0_op,
  input  logic [XPR_LEN-1:0]      req0_in1,
  input  logic [XPR_LEN-1:0]      req0_in2,
  input  logic [TAG_W-1:0]        req0_tag,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [ALU_OP_WIDTH-1:0] req1_op,
  input  logic [XPR_LEN-1:0]      req1_in1,
  input  logic [XPR_LEN-1:0]      req1_in2,
  input  logic [TAG_W-1:0]        req1_tag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [XPR_LEN-1:0]      res_data,
  output logic [TAG_W-1:0]        res_tag,
  output logic                    res_src,
  output logic [CNT_W-1:0]        grant_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);
  import alu_issue_arbiter_pkg::*;

  logic                    rr_q, rr_d;
  logic                    res_valid_q, res_valid_d;
  logic [XPR_LEN-1:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0]        res_tag_q, res_tag_d;
  logic                    res_src_q, res_src_d;
  logic [CNT_W-1:0]        grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  logic                    slot_free_s;
  logic                    any_req_s;
  logic                    grant_s;
  logic                    grant_idx_s;
  logic [ALU_OP_WIDTH-1:0] alu_op_s;
  logic [XPR_LEN-1:0]      alu_in1_s;
  logic [XPR_LEN-1:0]      alu_in2_s;
  logic [XPR_LEN-1:0]      alu_out_s;
  logic [TAG_W-1:0]        tag_sel_s;

  // Grant decision: nothing is accepted under reset/kill or while the result slot is occupied.
  always_comb begin
    slot_free_s = !res_valid_q || res_ready;
    any_req_s   = req0_valid || req1_valid;
    grant_s     = any_req_s && slot_free_s && !kill && !reset;
    if (grant_s) begin
      grant_idx_s = rr_pick(req0_valid, req1_valid, rr_q);
    end else begin
      grant_idx_s = 1'b0;
    end
  end

  assign req0_ready = grant_s && !grant_idx_s;
  assign req1_ready = grant_s &&  grant_idx_s;

  // Operand mux into the shared ALU.
  always_comb begin
    if (grant_idx_s) begin
      alu_op_s  = req1_op;
      alu_in1_s = req1_in1;
      alu_in2_s = req1_in2;
      tag_sel_s = req1_tag;
    end else begin
      alu_op_s  = req0_op;
      alu_in1_s = req0_in1;
      alu_in2_s = req0_in2;
      tag_sel_s = req0_tag;
    end
  end

  alu_issue_arbiter_alu #(
    .ALU_OP_WIDTH(ALU_OP_WIDTH),
    .XPR_LEN     (XPR_LEN)
  ) u_alu (
    .op (alu_op_s),
    .in1(alu_in1_s),
    .in2(alu_in2_s),
    .out(alu_out_s)
  );

  // Next state: kill beats a grant, and a grant beats a plain drain so back-to-back issue is lossless.
  always_comb begin
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    res_src_d  = res_src_q;
    if (kill) begin
      res_valid_d = 1'b0;
    end else if (grant_s) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out_s;
      res_tag_d   = tag_sel_s;
      res_src_d   = grant_idx_s;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end

    if (grant_s) begin
      rr_d = !grant_idx_s;
    end else begin
      rr_d = rr_q;
    end

    if (grant_s && (grant_cnt_q != {CNT_W{1'b1}})) begin
      grant_cnt_d = grant_cnt_q + CNT_W'(1);
    end else begin
      grant_cnt_d = grant_cnt_q;
    end

    if (any_req_s && !grant_s && !kill && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {XPR_LEN{1'b0}};
      res_tag_q   <= {TAG_W{1'b0}};
      res_src_q   <= 1'b0;
      grant_cnt_q <= {CNT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      rr_q        <= rr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_src_q   <= res_src_d;
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_src   = res_src_q;
  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench: directed vector table, counter saturation / reset sequences, then random traffic vs a model.
module tb_alu_issue_arbiter;

  logic        clk = 1'b0;
  logic        reset, kill, res_ready;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [5:0]  req0_tag, req1_tag;
  logic        req0_ready, req1_ready, res_valid, res_src;
  logic [31:0] res_data;
  logic [5:0]  res_tag;
  logic [15:0] grant_cnt, stall_cnt;

  alu_issue_arbiter dut (
    .clk(clk), .reset(reset), .kill(kill),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_src(res_src),
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: the held result, who won last, and plain integer counters.
  bit          m_rv;
  logic [31:0] m_data;
  logic [5:0]  m_tag;
  bit          m_src;
  int          m_last;
  int          m_g, m_s;
  bit          pend0, pend1;
  localparam int CMAX = 65535;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd10:   return a - b;
      4'd1:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd11:   return sa >>> b[4:0];
      4'd4:    return a ^ b;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return (a == b) ? 32'd1 : 32'd0;
      4'd9:    return (a != b) ? 32'd1 : 32'd0;
      4'd12:   return (sa <  sb) ? 32'd1 : 32'd0;
      4'd13:   return (sa >= sb) ? 32'd1 : 32'd0;
      4'd14:   return (a <  b) ? 32'd1 : 32'd0;
      4'd15:   return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_grant(output bit g, output int who);
    g = 0;
    who = 0;
    if (!reset && !kill && (!m_rv || res_ready)) begin
      if (req0_valid && req1_valid) begin g = 1; who = 1 - m_last; end
      else if (req0_valid) begin g = 1; who = 0; end
      else if (req1_valid) begin g = 1; who = 1; end
    end
  endtask

  // One clock: check readies before the edge, advance the model at the edge, check outputs after.
  task automatic cycle(input bit check);
    bit g;
    int who;
    #1;
    model_grant(g, who);
    if (check) begin
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, g && who == 0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, g && who == 1});
    end
    pend0 = req0_valid && !(g && who == 0);
    pend1 = req1_valid && !(g && who == 1);
    @(posedge clk);
    if (reset) begin
      m_rv = 0; m_data = 32'd0; m_tag = 6'd0; m_src = 0; m_last = 1; m_g = 0; m_s = 0;
    end else begin
      if (kill) m_rv = 0;
      else if (g) begin
        m_rv   = 1;
        m_src  = (who == 1);
        m_data = (who == 1) ? alu_ref(req1_op, req1_in1, req1_in2) : alu_ref(req0_op, req0_in1, req0_in2);
        m_tag  = (who == 1) ? req1_tag : req0_tag;
      end else if (m_rv && res_ready) m_rv = 0;
      if (g) begin
        m_last = who;
        if (m_g < CMAX) m_g++;
      end
      if ((req0_valid || req1_valid) && !g && !kill && m_s < CMAX) m_s++;
    end
    #1;
    if (check) begin
      chk("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
      chk("res_data", res_data, m_data);
      chk("res_tag", {26'd0, res_tag}, {26'd0, m_tag});
      chk("res_src", {31'd0, res_src}, {31'd0, m_src});
      chk("grant_cnt", {16'd0, grant_cnt}, m_g);
      chk("stall_cnt", {16'd0, stall_cnt}, m_s);
    end
  endtask

  typedef struct {
    logic kill; logic rrdy;
    logic v0; logic [3:0] op0; logic [31:0] a0; logic [31:0] b0; logic [5:0] t0;
    logic v1; logic [3:0] op1; logic [31:0] a1; logic [31:0] b1; logic [5:0] t1;
    logic e_r0; logic e_r1; logic e_rv; logic [31:0] e_data; logic [5:0] e_tag; logic e_src;
    int e_g; int e_s;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // kill rrdy | v0 op a b tag | v1 op a b tag | r0 r1 | rv data tag src | grants stalls
    tbl[0]  = '{1'b0,1'b1, 1'b1,4'd0,32'd5,32'd7,6'd3,  1'b0,4'd0,32'd0,32'd0,6'd0,   1'b1,1'b0, 1'b1,32'd12,6'd3,1'b0, 1,0};
    tbl[1]  = '{1'b0,1'b1, 1'b1,4'd0,32'd1,32'd1,6'd1,  1'b1,4'd0,32'd2,32'd2,6'd2,   1'b0,1'b1, 1'b1,32'd4,6'd2,1'b1, 2,0};
    tbl[2]  = '{1'b0,1'b1, 1'b1,4'd0,32'd1,32'd1,6'd1,  1'b1,4'd10,32'd9,32'd4,6'd5,  1'b1,1'b0, 1'b1,32'd2,6'd1,1'b0, 3,0};
    tbl[3]  = '{1'b0,1'b1, 1'b1,4'd0,32'd6,32'd6,6'd7,  1'b1,4'd10,32'd9,32'd4,6'd5,  1'b0,1'b1, 1'b1,32'd5,6'd5,1'b1, 4,0};
    tbl[4]  = '{1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0,6'd0,  1'b1,4'd10,32'd10,32'd3,6'd9, 1'b0,1'b0, 1'b1,32'd5,6'd5,1'b1, 4,1};
    tbl[5]  = '{1'b0,1'b0, 1'b0,4'd0,32'd0,32'd0,6'd0,  1'b1,4'd10,32'd10,32'd3,6'd9, 1'b0,1'b0, 1'b1,32'd5,6'd5,1'b1, 4,2};
    tbl[6]  = '{1'b0,1'b1, 1'b0,4'd0,32'd0,32'd0,6'd0,  1'b1,4'd10,32'd10,32'd3,6'd9, 1'b0,1'b1, 1'b1,32'd7,6'd9,1'b1, 5,2};
    tbl[7]  = '{1'b1,1'b0, 1'b1,4'd0,32'd1,32'd2,6'd4,  1'b0,4'd0,32'd0,32'd0,6'd0,   1'b0,1'b0, 1'b0,32'd7,6'd9,1'b1, 5,2};
    tbl[8]  = '{1'b0,1'b0, 1'b1,4'd0,32'd1,32'd2,6'd4,  1'b0,4'd0,32'd0,32'd0,6'd0,   1'b1,1'b0, 1'b1,32'd3,6'd4,1'b0, 6,2};
    tbl[9]  = '{1'b1,1'b1, 1'b1,4'd11,32'h80000000,32'd4,6'd10, 1'b1,4'd12,32'hFFFFFFFF,32'd1,6'd11, 1'b0,1'b0, 1'b0,32'd3,6'd4,1'b0, 6,2};
    tbl[10] = '{1'b0,1'b1, 1'b1,4'd11,32'h80000000,32'd4,6'd10, 1'b1,4'd12,32'hFFFFFFFF,32'd1,6'd11, 1'b0,1'b1, 1'b1,32'd1,6'd11,1'b1, 7,2};
    tbl[11] = '{1'b0,1'b1, 1'b1,4'd11,32'h80000000,32'd4,6'd10, 1'b0,4'd0,32'd0,32'd0,6'd0, 1'b1,1'b0, 1'b1,32'hF8000000,6'd10,1'b0, 8,2};
    tbl[12] = '{1'b0,1'b1, 1'b0,4'd0,32'd0,32'd0,6'd0,  1'b1,4'd3,32'd55,32'd66,6'd12, 1'b0,1'b1, 1'b1,32'd0,6'd12,1'b1, 9,2};
    tbl[13] = '{1'b0,1'b1, 1'b0,4'd0,32'd0,32'd0,6'd0,  1'b0,4'd0,32'd0,32'd0,6'd0,   1'b0,1'b0, 1'b0,32'd0,6'd12,1'b1, 9,2};
    tbl[14] = '{1'b0,1'b1, 1'b1,4'd0,32'd3,32'd3,6'd13, 1'b1,4'd0,32'd4,32'd4,6'd14,  1'b1,1'b0, 1'b1,32'd6,6'd13,1'b0, 10,2};

    reset = 1'b1; kill = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_in1 = 32'd1; req0_in2 = 32'd1; req0_tag = 6'd1;
    req1_valid = 1'b1; req1_op = 4'd0; req1_in1 = 32'd2; req1_in2 = 32'd2; req1_tag = 6'd2;
    m_last = 1;
    cycle(1);
    cycle(1);
    reset = 1'b0;

    foreach (tbl[i]) begin
      kill = tbl[i].kill; res_ready = tbl[i].rrdy;
      req0_valid = tbl[i].v0; req0_op = tbl[i].op0; req0_in1 = tbl[i].a0; req0_in2 = tbl[i].b0; req0_tag = tbl[i].t0;
      req1_valid = tbl[i].v1; req1_op = tbl[i].op1; req1_in1 = tbl[i].a1; req1_in2 = tbl[i].b1; req1_tag = tbl[i].t1;
      #1;
      chk($sformatf("row%0d_r0", i), {31'd0, req0_ready}, {31'd0, tbl[i].e_r0});
      chk($sformatf("row%0d_r1", i), {31'd0, req1_ready}, {31'd0, tbl[i].e_r1});
      cycle(1);
      chk($sformatf("row%0d_rv", i), {31'd0, res_valid}, {31'd0, tbl[i].e_rv});
      chk($sformatf("row%0d_data", i), res_data, tbl[i].e_data);
      chk($sformatf("row%0d_tag", i), {26'd0, res_tag}, {26'd0, tbl[i].e_tag});
      chk($sformatf("row%0d_src", i), {31'd0, res_src}, {31'd0, tbl[i].e_src});
      chk($sformatf("row%0d_gcnt", i), {16'd0, grant_cnt}, tbl[i].e_g);
      chk($sformatf("row%0d_scnt", i), {16'd0, stall_cnt}, tbl[i].e_s);
    end

    // Hold the result with no consumer so req0 stalls long enough to saturate stall_cnt.
    kill = 1'b0; res_ready = 1'b0; req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_in1 = 32'd8; req0_in2 = 32'd8; req0_tag = 6'd20;
    for (int i = 0; i < 65539; i++) cycle(0);
    cycle(1);
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("grant_hold", {16'd0, grant_cnt}, 32'd10);
    chk("rv_before_reset", {31'd0, res_valid}, 32'd1);

    // Reset while a result is held: dropped without handshake.
    reset = 1'b1; res_ready = 1'b1;
    #1;
    chk("rst_r0", {31'd0, req0_ready}, 32'd0);
    chk("rst_r1", {31'd0, req1_ready}, 32'd0);
    cycle(1);
    chk("rst_rv", {31'd0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_tag", {26'd0, res_tag}, 32'd0);
    chk("rst_src", {31'd0, res_src}, 32'd0);
    chk("rst_gcnt", {16'd0, grant_cnt}, 32'd0);
    chk("rst_scnt", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;

    // Random traffic; a requester left waiting keeps its fields stable.
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op    = 4'($urandom_range(0, 15));
        req0_in1   = $urandom;
        req0_in2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        req0_tag   = 6'($urandom_range(0, 63));
      end
      if (!pend1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_op    = 4'($urandom_range(0, 15));
        req1_in1   = $urandom;
        req1_in2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        req1_tag   = 6'($urandom_range(0, 63));
      end
      kill      = ($urandom_range(0, 15) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 199) == 0);
      cycle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
